// File: rtl/inst_decoder_if.sv
// RV32I decode-stage bus: instruction/PC/flush from fetch, decoded fields and controls to execute.
// Latency: none (wires only); the decoder sets the pipeline depth.
// Backpressure: none; the consumer must accept one decoded instruction per cycle.
// Ports: master = fetch side (drives iInst/iCurPC/iFlushPipe), slave = decoder (drives all o* signals).
interface inst_decoder_if;
  logic [31:0] iInst;
  logic [31:0] iCurPC;
  logic        iFlushPipe;
  logic [4:0]  oRs1Addr;
  logic [4:0]  oRs2Addr;
  logic [4:0]  oRdAddr;
  logic [2:0]  oF3;
  logic [6:0]  oF7;
  logic [31:0] oImm;
  logic [6:0]  oOpcode;
  logic [31:0] oCurPc;
  logic        oLoad;
  logic        oStore;
  logic        oMemDv;
  logic [3:0]  oAritType;
  logic        oOpRs1;
  logic        oOpRs2;
  logic        oOpImm;
  logic        oOpPc;
  logic        oOpConst;
  logic        oOpDv;
  logic [3:0]  oBrOp;
  logic        oBrDv;

  modport master (
    output iInst, iCurPC, iFlushPipe,
    input  oRs1Addr, oRs2Addr, oRdAddr, oF3, oF7, oImm, oOpcode, oCurPc,
           oLoad, oStore, oMemDv, oAritType, oOpRs1, oOpRs2, oOpImm, oOpPc,
           oOpConst, oOpDv, oBrOp, oBrDv
  );

  modport slave (
    input  iInst, iCurPC, iFlushPipe,
    output oRs1Addr, oRs2Addr, oRdAddr, oF3, oF7, oImm, oOpcode, oCurPc,
           oLoad, oStore, oMemDv, oAritType, oOpRs1, oOpRs2, oOpImm, oOpPc,
           oOpConst, oOpDv, oBrOp, oBrDv
  );
endinterface

// File: rtl/inst_decoder.sv
// RV32I instruction decoder: raw fields, sign-extended immediate, ALU/memory/branch controls.
// Latency: cycleNum (1 or 2) edges from iInst sample to aligned outputs; iRst/iFlushPipe clear every stage.
// Backpressure: none; accepts one instruction every cycle and never stalls.
// Ports: iClk, iRst (sync, active-high) plain; everything else on bus (inst_decoder_if.slave).
module inst_decoder #(
  parameter int cycleNum = 2  // 1: single register stage, otherwise two stages
) (
  input  logic           iClk,
  input  logic           iRst,
  inst_decoder_if.slave  bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  opcode;
    logic [31:0] imm;
    logic [31:0] pc;
  } fields_t;

  typedef struct packed {
    logic       load;
    logic       store;
    logic       memDv;
    logic [3:0] aritType;
    logic       opRs1;
    logic       opRs2;
    logic       opImm;
    logic       opPc;
    logic       opConst;
    logic       opDv;
    logic [3:0] brOp;
    logic       brDv;
  } ctrl_t;

  // Raw field split plus immediate; rd is zeroed for formats that have no destination.
  function automatic fields_t extractFields(input logic [31:0] inst, input logic [31:0] pc);
    fields_t f;
    f        = '0;
    f.rs1    = inst[19:15];
    f.rs2    = inst[24:20];
    f.f3     = inst[14:12];
    f.f7     = inst[31:25];
    f.opcode = inst[6:0];
    f.pc     = pc;
    f.rd     = (inst[6:0] == OPC_STORE || inst[6:0] == OPC_BRANCH) ? 5'd0 : inst[11:7];
    case (inst[6:0])
      OPC_OPIMM, OPC_LOAD, OPC_JALR:
        f.imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:
        f.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:
        f.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        f.imm = {inst[31:12], 12'b0};
      OPC_JAL:
        f.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        f.imm = '0;
    endcase
    return f;
  endfunction

  // funct3 -> ALU op. alt is inst[30] (f7[5]); SUB only exists for register-register ops.
  function automatic logic [3:0] aluOp(input logic [2:0] f3, input logic alt, input logic allowSub);
    logic [3:0] op;
    op = 4'd0;
    case (f3)
      3'b000:  op = (alt && allowSub) ? 4'd1 : 4'd0;
      3'b001:  op = 4'd2;
      3'b010:  op = 4'd3;
      3'b011:  op = 4'd4;
      3'b100:  op = 4'd5;
      3'b101:  op = alt ? 4'd7 : 4'd6;
      3'b110:  op = 4'd8;
      default: op = 4'd9;
    endcase
    return op;
  endfunction

  // Control decode; unknown opcodes (incl. FENCE/SYSTEM/all-zero) leave everything at 0.
  function automatic ctrl_t decodeCtrl(input logic [6:0] opcode, input logic [2:0] f3, input logic alt);
    ctrl_t c;
    c = '0;
    case (opcode)
      OPC_OP: begin
        c.aritType = aluOp(f3, alt, 1'b1);
        c.opRs1    = 1'b1;
        c.opRs2    = 1'b1;
        c.opDv     = 1'b1;
      end
      OPC_OPIMM: begin
        c.aritType = aluOp(f3, alt, 1'b0);
        c.opRs1    = 1'b1;
        c.opImm    = 1'b1;
        c.opDv     = 1'b1;
      end
      OPC_LUI: begin
        // A operand is implicitly zero: neither opRs1 nor opPc is set.
        c.opImm = 1'b1;
        c.opDv  = 1'b1;
      end
      OPC_AUIPC: begin
        c.opPc  = 1'b1;
        c.opImm = 1'b1;
        c.opDv  = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // ALU produces the link address PC+4; the branch unit computes the target.
        c.opPc    = 1'b1;
        c.opConst = 1'b1;
        c.opDv    = 1'b1;
        c.brOp    = (opcode == OPC_JAL) ? 4'd8 : 4'd9;
        c.brDv    = 1'b1;
      end
      OPC_BRANCH: begin
        c.opRs1 = 1'b1;
        c.opRs2 = 1'b1;
        c.brOp  = {1'b0, f3};
        c.brDv  = 1'b1;
      end
      OPC_LOAD: begin
        c.opRs1 = 1'b1;
        c.opImm = 1'b1;
        c.load  = 1'b1;
        c.memDv = 1'b1;
      end
      OPC_STORE: begin
        c.opRs1 = 1'b1;
        c.opImm = 1'b1;
        c.store = 1'b1;
        c.memDv = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  fields_t outFields;
  ctrl_t   outCtrl;

  generate
    if (cycleNum == 1) begin : gSingle
      always_ff @(posedge iClk) begin
        if (iRst || bus.iFlushPipe) begin
          outFields <= '0;
          outCtrl   <= '0;
        end else begin
          outFields <= extractFields(bus.iInst, bus.iCurPC);
          outCtrl   <= decodeCtrl(bus.iInst[6:0], bus.iInst[14:12], bus.iInst[30]);
        end
      end
    end else begin : gDual
      fields_t s1Fields;

      // Stage 1 holds fields/immediate; stage 2 adds the control decode from those fields.
      // A clear wipes both stages, so the instruction sampled with the flush never emerges.
      always_ff @(posedge iClk) begin
        if (iRst || bus.iFlushPipe) begin
          s1Fields  <= '0;
          outFields <= '0;
          outCtrl   <= '0;
        end else begin
          s1Fields  <= extractFields(bus.iInst, bus.iCurPC);
          outFields <= s1Fields;
          outCtrl   <= decodeCtrl(s1Fields.opcode, s1Fields.f3, s1Fields.f7[5]);
        end
      end
    end
  endgenerate

  assign bus.oRs1Addr  = outFields.rs1;
  assign bus.oRs2Addr  = outFields.rs2;
  assign bus.oRdAddr   = outFields.rd;
  assign bus.oF3       = outFields.f3;
  assign bus.oF7       = outFields.f7;
  assign bus.oImm      = outFields.imm;
  assign bus.oOpcode   = outFields.opcode;
  assign bus.oCurPc    = outFields.pc;
  assign bus.oLoad     = outCtrl.load;
  assign bus.oStore    = outCtrl.store;
  assign bus.oMemDv    = outCtrl.memDv;
  assign bus.oAritType = outCtrl.aritType;
  assign bus.oOpRs1    = outCtrl.opRs1;
  assign bus.oOpRs2    = outCtrl.opRs2;
  assign bus.oOpImm    = outCtrl.opImm;
  assign bus.oOpPc     = outCtrl.opPc;
  assign bus.oOpConst  = outCtrl.opConst;
  assign bus.oOpDv     = outCtrl.opDv;
  assign bus.oBrOp     = outCtrl.brOp;
  assign bus.oBrDv     = outCtrl.brDv;

endmodule

// File: tb/tb_inst_decoder.sv
// Bench for inst_decoder: drives cycleNum=1 and cycleNum=2 instances with identical stimulus.
// Checks a table of known encodings, flush/reset sequences, then random instructions
// against a history-based reference model.
module tb_inst_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_decoder_if bus1();
  inst_decoder_if bus2();

  inst_decoder #(.cycleNum(1)) dut1 (.iClk(clk), .iRst(rst), .bus(bus1));
  inst_decoder #(.cycleNum(2)) dut2 (.iClk(clk), .iRst(rst), .bus(bus2));

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [31:0] curPc;
    logic        load;
    logic        store;
    logic        memDv;
    logic [3:0]  arit;
    logic        opRs1;
    logic        opRs2;
    logic        opImm;
    logic        opPc;
    logic        opConst;
    logic        opDv;
    logic [3:0]  brOp;
    logic        brDv;
  } out_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [17:0] ctl;
  } vec_t;

  out_t act1, act2;
  assign act1 = {bus1.oRs1Addr, bus1.oRs2Addr, bus1.oRdAddr, bus1.oF3, bus1.oF7, bus1.oImm,
                 bus1.oOpcode, bus1.oCurPc, bus1.oLoad, bus1.oStore, bus1.oMemDv, bus1.oAritType,
                 bus1.oOpRs1, bus1.oOpRs2, bus1.oOpImm, bus1.oOpPc, bus1.oOpConst, bus1.oOpDv,
                 bus1.oBrOp, bus1.oBrDv};
  assign act2 = {bus2.oRs1Addr, bus2.oRs2Addr, bus2.oRdAddr, bus2.oF3, bus2.oF7, bus2.oImm,
                 bus2.oOpcode, bus2.oCurPc, bus2.oLoad, bus2.oStore, bus2.oMemDv, bus2.oAritType,
                 bus2.oOpRs1, bus2.oOpRs2, bus2.oOpImm, bus2.oOpPc, bus2.oOpConst, bus2.oOpDv,
                 bus2.oBrOp, bus2.oBrDv};

  int tests = 0;
  int failed = 0;

  // Input history: one entry per clock edge, clr = reset or flush at that edge.
  logic [31:0] hInst [4096];
  logic [31:0] hPc   [4096];
  logic        hClr  [4096];
  int          edgeIdx = 0;

  function automatic logic [17:0] ctl(input logic ld, input logic st, input logic md,
                                      input logic [3:0] ar, input logic r1, input logic r2,
                                      input logic im, input logic pc, input logic cn,
                                      input logic dv, input logic [3:0] br, input logic bd);
    return {ld, st, md, ar, r1, r2, im, pc, cn, dv, br, bd};
  endfunction

  function automatic out_t expOf(input vec_t v);
    out_t o;
    o = {v.rs1, v.rs2, v.rd, v.inst[14:12], v.inst[31:25], v.imm, v.inst[6:0], v.pc, v.ctl};
    return o;
  endfunction

  function automatic logic [3:0] aluRef(input logic [2:0] f3, input logic alt, input logic isReg);
    logic [3:0] base [8];
    base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    if (f3 == 3'd0 && alt && isReg) return 4'd1;
    if (f3 == 3'd5 && alt) return 4'd7;
    return base[f3];
  endfunction

  // Reference decode from the ISA rules; immediates built with signed integer arithmetic.
  function automatic out_t refDecode(input logic [31:0] inst, input logic [31:0] pc);
    out_t o;
    int   s;
    int   hi;
    s  = int'(inst);
    hi = s >>> 31;  // 0 or -1
    o = '0;
    o.rs1 = inst[19:15];
    o.rs2 = inst[24:20];
    o.rd = inst[11:7];
    o.f3 = inst[14:12];
    o.f7 = inst[31:25];
    o.opcode = inst[6:0];
    o.curPc = pc;
    case (inst[6:0])
      7'h33: begin o.arit = aluRef(inst[14:12], inst[30], 1'b1); o.opRs1 = 1; o.opRs2 = 1; o.opDv = 1; end
      7'h13: begin
        o.imm = 32'(s >>> 20);
        o.arit = aluRef(inst[14:12], inst[30], 1'b0); o.opRs1 = 1; o.opImm = 1; o.opDv = 1;
      end
      7'h37: begin o.imm = inst & 32'hFFFF_F000; o.opImm = 1; o.opDv = 1; end
      7'h17: begin o.imm = inst & 32'hFFFF_F000; o.opImm = 1; o.opPc = 1; o.opDv = 1; end
      7'h6F: begin
        o.imm = 32'(hi * 1048576 + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048
                    + int'(inst[30:21]) * 2);
        o.opPc = 1; o.opConst = 1; o.opDv = 1; o.brOp = 4'd8; o.brDv = 1;
      end
      7'h67: begin
        o.imm = 32'(s >>> 20);
        o.opPc = 1; o.opConst = 1; o.opDv = 1; o.brOp = 4'd9; o.brDv = 1;
      end
      7'h63: begin
        o.rd = 5'd0;
        o.imm = 32'(hi * 4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32
                    + int'(inst[11:8]) * 2);
        o.opRs1 = 1; o.opRs2 = 1; o.brOp = {1'b0, inst[14:12]}; o.brDv = 1;
      end
      7'h03: begin o.imm = 32'(s >>> 20); o.opRs1 = 1; o.opImm = 1; o.load = 1; o.memDv = 1; end
      7'h23: begin
        o.rd = 5'd0;
        o.imm = 32'((s >>> 25) * 32 + int'(inst[11:7]));
        o.opRs1 = 1; o.opImm = 1; o.store = 1; o.memDv = 1;
      end
      default: begin o = '0; o.rs1 = inst[19:15]; o.rs2 = inst[24:20]; o.rd = inst[11:7];
                     o.f3 = inst[14:12]; o.f7 = inst[31:25]; o.opcode = inst[6:0]; o.curPc = pc; end
    endcase
    return o;
  endfunction

  // Output after edge idx for latency lat: the instruction from edge idx-lat+1,
  // or all zero if any clear happened in between.
  function automatic out_t modelAt(input int idx, input int lat);
    int src;
    src = idx - lat + 1;
    if (src < 0) return '0;
    for (int j = src; j <= idx; j++)
      if (hClr[j]) return '0;
    return refDecode(hInst[src], hPc[src]);
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive at the negedge, clock one edge, then compare both DUTs against the model.
  task automatic step(input logic [31:0] inst, input logic [31:0] pc, input logic fl, input logic r);
    bus1.iInst = inst; bus1.iCurPC = pc; bus1.iFlushPipe = fl;
    bus2.iInst = inst; bus2.iCurPC = pc; bus2.iFlushPipe = fl;
    rst = r;
    @(posedge clk);
    hInst[edgeIdx] = inst;
    hPc[edgeIdx]   = pc;
    hClr[edgeIdx]  = r | fl;
    @(negedge clk);
    check($sformatf("model_lat1_e%0d", edgeIdx), act1, modelAt(edgeIdx, 1));
    check($sformatf("model_lat2_e%0d", edgeIdx), act2, modelAt(edgeIdx, 2));
    edgeIdx++;
  endtask

  vec_t vecs [12];
  logic [6:0] opList [11];

  initial begin
    vecs[0]  = '{32'h002081B3, 32'h0000_1000, 5'd1, 5'd2, 5'd3, 32'd0,
                 ctl(0,0,0,4'd0,1,1,0,0,0,1,4'd0,0)};  // ADD
    vecs[1]  = '{32'h402081B3, 32'h0000_1004, 5'd1, 5'd2, 5'd3, 32'd0,
                 ctl(0,0,0,4'd1,1,1,0,0,0,1,4'd0,0)};  // SUB
    vecs[2]  = '{32'h00500093, 32'h0000_1008, 5'd0, 5'd5, 5'd1, 32'd5,
                 ctl(0,0,0,4'd0,1,0,1,0,0,1,4'd0,0)};  // ADDI x1,x0,5
    vecs[3]  = '{32'h123452B7, 32'h0000_100C, 5'd8, 5'd3, 5'd5, 32'h1234_5000,
                 ctl(0,0,0,4'd0,0,0,1,0,0,1,4'd0,0)};  // LUI x5
    vecs[4]  = '{32'h0020A423, 32'h0000_1010, 5'd1, 5'd2, 5'd0, 32'd8,
                 ctl(0,1,1,4'd0,1,0,1,0,0,0,4'd0,0)};  // SW x2,8(x1)
    vecs[5]  = '{32'h00208863, 32'h0000_1014, 5'd1, 5'd2, 5'd0, 32'd16,
                 ctl(0,0,0,4'd0,1,1,0,0,0,0,4'd0,1)};  // BEQ +16
    vecs[6]  = '{32'hFFDFF0EF, 32'h0000_0100, 5'd31, 5'd29, 5'd1, 32'hFFFF_FFFC,
                 ctl(0,0,0,4'd0,0,0,0,1,1,1,4'd8,1)};  // JAL x1,-4
    vecs[7]  = '{32'h0040A183, 32'h0000_1018, 5'd1, 5'd4, 5'd3, 32'd4,
                 ctl(1,0,1,4'd0,1,0,1,0,0,0,4'd0,0)};  // LW x3,4(x1)
    vecs[8]  = '{32'h4030D093, 32'h0000_101C, 5'd1, 5'd3, 5'd1, 32'h0000_0403,
                 ctl(0,0,0,4'd7,1,0,1,0,0,1,4'd0,0)};  // SRAI x1,x1,3
    vecs[9]  = '{32'h000080E7, 32'h0000_1020, 5'd1, 5'd0, 5'd1, 32'd0,
                 ctl(0,0,0,4'd0,0,0,0,1,1,1,4'd9,1)};  // JALR x1,0(x1)
    vecs[10] = '{32'h00001517, 32'h0000_1024, 5'd0, 5'd0, 5'd10, 32'h0000_1000,
                 ctl(0,0,0,4'd0,0,0,1,1,0,1,4'd0,0)};  // AUIPC x10,1
    vecs[11] = '{32'h00000000, 32'h0000_1028, 5'd0, 5'd0, 5'd0, 32'd0,
                 ctl(0,0,0,4'd0,0,0,0,0,0,0,4'd0,0)};  // all-zero word
    opList = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h0F, 7'h73};

    // Reset state
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    check("reset_lat1", act1, '0);
    check("reset_lat2", act2, '0);

    // Table: hold each instruction two edges so both latencies show it.
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].inst, vecs[i].pc, 1'b0, 1'b0);
      step(vecs[i].inst, vecs[i].pc, 1'b0, 1'b0);
      check($sformatf("vec%0d_lat1", i), act1, expOf(vecs[i]));
      check($sformatf("vec%0d_lat2", i), act2, expOf(vecs[i]));
    end

    // Five back-to-back instructions, flush sampled with the third.
    step(vecs[0].inst, vecs[0].pc, 1'b0, 1'b0);
    step(vecs[1].inst, vecs[1].pc, 1'b0, 1'b0);
    step(vecs[2].inst, vecs[2].pc, 1'b1, 1'b0);
    check("flush_edge_lat1", act1, '0);
    check("flush_edge_lat2", act2, '0);
    step(vecs[3].inst, vecs[3].pc, 1'b0, 1'b0);
    check("after_flush_lat1", act1, expOf(vecs[3]));
    check("after_flush_lat2_bubble", act2, '0);
    step(vecs[4].inst, vecs[4].pc, 1'b0, 1'b0);
    check("after_flush2_lat1", act1, expOf(vecs[4]));
    check("after_flush2_lat2", act2, expOf(vecs[3]));

    // Reset mid-stream, then an all-zero instruction.
    step(vecs[5].inst, vecs[5].pc, 1'b0, 1'b0);
    step(vecs[6].inst, vecs[6].pc, 1'b0, 1'b0);
    step(vecs[7].inst, vecs[7].pc, 1'b1, 1'b1);
    check("midrst_lat1", act1, '0);
    check("midrst_lat2", act2, '0);
    step(32'h0, 32'h0, 1'b0, 1'b0);
    step(32'h0, 32'h0, 1'b0, 1'b0);
    check("zero_inst_lat1", act1, '0);
    check("zero_inst_lat2", act2, '0);

    // Random instructions with occasional flush/reset against the model.
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] r;
      logic [31:0] inst;
      logic [6:0]  op;
      r = $urandom();
      if ($urandom_range(0, 9) == 0) op = r[6:0];
      else op = opList[$urandom_range(0, 10)];
      inst = {r[31:7], op};
      step(inst, $urandom(), ($urandom_range(0, 11) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/inst_decoder.md
Name: inst_decoder

Overview:
RV32I instruction decode stage that sits between fetch and execute/memory/branch units. Splits a 32-bit instruction into register addresses, funct fields, opcode and sign-extended immediate. Produces ALU operand-select and operation controls, memory load/store flags and branch/jump controls. All outputs are registered with a parameterised latency; a pipeline flush invalidates in-flight instructions.

Parameters:
- cycleNum, 2, output latency in clock edges from iInst sample to outputs; legal values 1 or 2.

Ports:
- iClk  in  1  clock, all logic on rising edge
- iRst  in  1  synchronous reset, active-high
- iInst  in  32  instruction word, sampled every rising edge
- iCurPC  in  32  PC of iInst
- iFlushPipe  in  1  flush: discard all in-flight instructions
- oRs1Addr  out  5  inst[19:15]
- oRs2Addr  out  5  inst[24:20]
- oRdAddr  out  5  inst[11:7]; forced 0 for S and B types
- oF3  out  3  inst[14:12]
- oF7  out  7  inst[31:25]
- oImm  out  32  sign-extended immediate; 0 for R-type and unknown opcodes
- oOpcode  out  7  inst[6:0]
- oCurPc  out  32  iCurPC delayed with the instruction
- oLoad  out  1  opcode 0000011
- oStore  out  1  opcode 0100011
- oMemDv  out  1  oLoad | oStore
- oAritType  out  4  ALU op: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
- oOpRs1  out  1  ALU A = rs1
- oOpRs2  out  1  ALU B = rs2
- oOpImm  out  1  ALU B = oImm
- oOpPc  out  1  ALU A = oCurPc
- oOpConst  out  1  ALU B = constant 4
- oOpDv  out  1  ALU result written to rd
- oBrOp  out  4  funct3 for B-type (0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU); 8 JAL; 9 JALR; 0 otherwise
- oBrDv  out  1  branch/jump valid

Behaviour:
- Immediates (sign bit inst[31]):
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
- OP (0110011): opRs1, opRs2, opDv. Arith from f3: 000 ADD (SUB if f7[5]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if f7[5]), 110 OR, 111 AND.
- OP-IMM (0010011): opRs1, opImm, opDv. Same f3 map; SUB never generated; 101 with f7[5] gives SRA.
- LUI (0110111): opImm only, A = 0, ADD, opDv.
- AUIPC (0010111): opPc, opImm, ADD, opDv.
- JAL (1101111): opPc, opConst, ADD, opDv; oBrOp = 8, oBrDv = 1.
- JALR (1100111): opPc, opConst, ADD, opDv; oBrOp = 9, oBrDv = 1. Target is rs1 + imm, computed by the branch unit.
- BRANCH (1100011): opRs1, opRs2, oBrOp = f3, oBrDv = 1, opDv = 0, arith ADD.
- LOAD: opRs1, opImm, ADD, oLoad = 1, oMemDv = 1, opDv = 0. Width/sign comes from oF3.
- STORE: opRs1, opImm, ADD, oStore = 1, oMemDv = 1, opDv = 0.
- Any other opcode (FENCE, SYSTEM, illegal): all control and dv outputs 0. Raw fields are still passed through.
- Pipeline:
  - cycleNum = 1: all outputs registered once from iInst/iCurPC.
  - cycleNum = 2: stage 1 registers iInst/iCurPC and extracts raw fields and immediate; stage 2 registers the control decode. All outputs are aligned, so an instruction sampled at edge N appears after edge N+cycleNum-1.
  - Back-to-back instructions are accepted every cycle; no stalls.
- Reset (iRst = 1 at an edge): every pipeline register and every output goes to 0. Reset wins over flush.
- Flush (iFlushPipe = 1 at an edge): all stage registers clear to 0 exactly as on reset, including the instruction sampled at that edge. Decoding resumes on the next edge with iFlushPipe = 0.
- Instruction 0x00000000 decodes as an unknown opcode: all dv = 0.

Test Plan:
- Reset, then iInst = 0x002081B3 (ADD x3,x1,x2) -> rs1 = 1, rs2 = 2, rd = 3, f3 = 0, f7 = 0, opcode = 0x33, imm = 0, arith = 0, opRs1 = opRs2 = opDv = 1, brDv = memDv = 0, after cycleNum edges. Repeat with 0x402081B3 -> arith = 1 (SUB).
- 0x00500093 (ADDI x1,x0,5) -> imm = 5, rd = 1, opRs1 = opImm = opDv = 1. Then 0x123452B7 (LUI x5) -> imm = 0x12345000, opImm = 1, opRs1 = 0, rd = 5.
- 0x0020A423 (SW x2,8(x1)) -> imm = 8, oStore = 1, oMemDv = 1, rd = 0, opDv = 0, f3 = 2.
- 0x00208863 (BEQ x1,x2,+16) -> imm = 16, brOp = 0, brDv = 1, rd = 0. Then 0xFFDFF0EF (JAL x1,-4) with iCurPC = 0x100 -> imm = 0xFFFFFFFC, brOp = 8, brDv = 1, opPc = opConst = opDv = 1, oCurPc = 0x100.
- Stream of 5 instructions back-to-back with iFlushPipe pulsed for one cycle mid-stream -> in-flight instructions and the one sampled with the flush produce all-zero outputs; the following instruction decodes correctly.
- iRst asserted mid-stream for one cycle -> all outputs 0 cycleNum edges later; 0x00000000 input -> all dv 0.
